// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding.
//   The unused encoding 2'd3 is decoded as IDLE by the controller.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// full_subtractor_bit
//   Purely combinational 1-bit full subtractor: computes x - y - bin.
//   Ports:
//     x    in  minuend bit
//     y    in  subtrahend bit
//     bin  in  borrow in
//     d    out difference bit
//     bout out borrow out
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b (mod 2^WIDTH), LSB first,
//   one bit per clock through a single full-subtractor cell.
//   Ports:
//     clk        in   system clock (rising edge)
//     rst        in   synchronous active-high reset
//     start      in   operation request, sampled only in IDLE
//     a, b       in   operands, captured on the accepting edge
//     busy       out  high while bits are being processed
//     done       out  one-cycle pulse when diff/borrow_out are updated
//     diff       out  result, held until the next completed operation
//     borrow_out out  final borrow (1 when a < b unsigned)
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_d_sh;      // upper result bits collected so far
  logic             r_borrow;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  full_subtractor_bit u_cell (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // New bit enters at the MSB; after WIDTH shifts the word is LSB-aligned.
  assign w_result = {w_d, r_d_sh};
  assign w_last   = (r_count == LAST_BIT);

  // Next-state logic.
  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_state_next = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_state_next = w_last ? ST_DONE : ST_SHIFT;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_d_sh       <= '0;
      r_borrow     <= 1'b0;
      r_count      <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_d_sh   <= '0;
            r_borrow <= 1'b0;
            r_count  <= '0;
          end
        end
        ST_SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_d_sh   <= w_result[WIDTH-1:1];
          r_borrow <= w_bout;
          r_count  <= r_count + CW'(1);
          // Publish only the completed word so diff never shows partials.
          if (w_last) begin
            r_diff       <= w_result;
            r_borrow_out <= w_bout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == ST_SHIFT);
  assign done       = (r_state == ST_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Counterpart of the team's full-adder datapath: instead of combining operands by addition, it removes b from a, using a single full-subtractor cell plus a registered borrow.
- Used by lab-level arithmetic units where area matters more than latency.
- Start/done handshake lets a controller or testbench sequence operations.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while state is SHIFT
done  output  1  one-cycle pulse, result valid
diff  output  WIDTH  a - b modulo 2^WIDTH; held until next accepted start
borrow_out  output  1  final borrow; 1 when a < b unsigned

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, sampled at a clock edge while rst=1:
  - state=IDLE
  - busy=0, done=0, diff=0, borrow_out=0
  - internal borrow=0, bit counter=0, operand shift registers=0
- rst overrides all other inputs, including mid-SHIFT. A partial result is discarded, and diff reads 0 after reset.
- FSM states:
  - IDLE: busy=0.
    - start=1 at edge k: load a_sh=a, b_sh=b; clear diff shift register, borrow and count; go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: busy=1, one bit per edge.
    - d = a_sh[0] ^ b_sh[0] ^ borrow
    - bnext = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow)
    - Shift d into the result MSB (right shift), so after WIDTH shifts the result is LSB-aligned.
    - a_sh and b_sh shift right; borrow <= bnext; count++.
    - When count reaches WIDTH-1, that edge processes the final bit, sets borrow_out=bnext and goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge k gives bits processed at edges k+1..k+WIDTH. done is high in the cycle following edge k+WIDTH.
- diff and borrow_out:
  - diff is driven from a separate result register, updated only at the final SHIFT edge, so it never shows partial results.
  - Both hold their values through IDLE until the next final edge or a reset.
- start handling:
  - Ignored in SHIFT and DONE; no queuing.
  - Back-to-back operation therefore costs WIDTH+2 cycles minimum.
  - a and b may change freely after the accepting edge.
- Arithmetic: unsigned modulo 2^WIDTH.
  - borrow_out=1 iff a < b.
  - a == b gives diff=0, borrow_out=0.
- Counter width is clog2(WIDTH) bits; no wrap-around hazard because of the explicit WIDTH-1 compare.

Decomposition:
- Shared include file holds the state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2); encoding 2'd3 recovers to IDLE.
- One natural sub-module, full_subtractor_bit, is a purely combinational 1-bit cell:
  - inputs: x, y, bin
  - outputs: d, bout
  - instantiated once in the datapath
  - unit-testable against the exhaustive 8-row truth table in the same style as the existing adder benches.

Test Plan:
1. Reset then a=100, b=37, start pulse → busy for 8 cycles; done pulse 9 cycles after the start edge; diff=63, borrow_out=0.
2. a=5, b=9 → diff=8'hFC (252), borrow_out=1.
3. a=8'hA5, b=8'hA5 → diff=0, borrow_out=0; then a=0, b=255 → diff=1, borrow_out=1 with back-to-back starts, second accepted only in IDLE.
4. Start, then hold start=1 with new operands a=1, b=1 during SHIFT → first result (a=200, b=50 → 150) unaffected; no second operation until IDLE.
5. Assert rst for one cycle at SHIFT bit 4 → next cycle state IDLE, busy=0, done=0, diff=0, borrow_out=0; no done pulse follows.
6. full_subtractor_bit: all 8 input combinations → (d, bout) = 000:00, 001:11, 010:11, 011:01, 100:10, 101:00, 110:00, 111:11.
